// File: rtl/cdie_pm_pkg.sv
// Shared types and default timing constants for the CDIE dielet power-management responder.
package cdie_pm_pkg;

  typedef enum logic [2:0] {
    Q_RUN,
    Q_REQUEST,
    Q_STOPPED,
    Q_EXIT,
    Q_DENIED,
    Q_CONTINUE
  } q_state_e;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_CNT_W        = 6;
  localparam int DEF_ACCEPT_DLY   = 4;
  localparam int DEF_DENY_TIMEOUT = 64;
  localparam int DEF_ISO_DLY      = 3;

endpackage

// File: rtl/cdie_pm_sync_cell.sv
// Multi-flop synchronizer for one asynchronous level input, with a selectable reset value.
module cdie_pm_sync_cell #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {STAGES{RST_VAL}};
    else     r_sync <= (r_sync << 1) | STAGES'(i_d);
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cdie_dielet_pm_responder.sv
// Dielet-side PM responder: Q-channel device, isolation ack and coherent drain ack,
// gated by a count of outstanding dielet transactions.
module cdie_dielet_pm_responder
  import cdie_pm_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int ACCEPT_DLY   = DEF_ACCEPT_DLY,
  parameter int DENY_TIMEOUT = DEF_DENY_TIMEOUT,
  parameter int ISO_DLY      = DEF_ISO_DLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             txn_start,
  input  logic             txn_done,
  input  logic             wake_req,
  input  logic             iso_req_b,
  output logic             iso_ack_b,
  input  logic             QREQn,
  output logic             QACCEPTn,
  output logic             QDENY,
  output logic             QACTIVE,
  input  logic             coherent_traffic_req,
  output logic             coherent_traffic_ack,
  output logic             txn_block,
  output logic [CNT_W-1:0] outstanding,
  output logic             pm_err
);

  localparam int IDLE_W = $clog2(ACCEPT_DLY + 1);
  localparam int TOT_W  = $clog2(DENY_TIMEOUT + 1);
  localparam int ISO_W  = $clog2(ISO_DLY + 1);

  logic w_sqreqn, w_s_iso_b, w_s_ctr;

  cdie_pm_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_qreq (
    .clk(clk), .rst(rst), .i_d(QREQn), .o_q(w_sqreqn));
  cdie_pm_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_iso (
    .clk(clk), .rst(rst), .i_d(iso_req_b), .o_q(w_s_iso_b));
  cdie_pm_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ctr (
    .clk(clk), .rst(rst), .i_d(coherent_traffic_req), .o_q(w_s_ctr));

  q_state_e          r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [TOT_W-1:0]  r_tot_cnt;
  logic [ISO_W-1:0]  r_iso_cnt;
  logic r_err, r_qaccept_n, r_qdeny, r_qactive, r_ctr_ack, r_txn_block;
  logic r_iso_ack, r_iso_pend, r_iso_dir;

  logic w_cnt_max, w_inc, w_dec, w_cnt_err, w_busy, w_q_err, w_blk_err;
  logic w_iso_tgt, w_accept, w_deny;

  assign w_cnt_max = (r_cnt == {CNT_W{1'b1}});
  assign w_inc     = txn_start & ~txn_done;
  assign w_dec     = txn_done & ~txn_start;
  assign w_cnt_err = (w_inc & w_cnt_max) | (w_dec & (r_cnt == '0));
  assign w_busy    = (r_cnt != '0) | txn_start | r_ctr_ack;
  assign w_q_err   = (r_state == Q_REQUEST) & w_sqreqn;
  assign w_blk_err = txn_start & r_txn_block;
  // A falling isolation request outside Q_STOPPED stays pending: the target holds at the current ack.
  assign w_iso_tgt = w_s_iso_b | ((r_state != Q_STOPPED) & r_iso_ack);
  assign w_accept  = (r_idle_cnt == IDLE_W'(ACCEPT_DLY - 1)) & ~w_busy;
  assign w_deny    = (r_tot_cnt == TOT_W'(DENY_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_qactive <= 1'b0;
    end else begin
      if (w_inc & ~w_cnt_max)          r_cnt <= r_cnt + 1'b1;
      else if (w_dec & (r_cnt != '0))  r_cnt <= r_cnt - 1'b1;
      if (w_cnt_err | w_q_err | w_blk_err) r_err <= 1'b1;
      r_qactive <= w_busy | wake_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= Q_STOPPED;
      r_qaccept_n <= 1'b0;
      r_qdeny     <= 1'b0;
      r_idle_cnt  <= '0;
      r_tot_cnt   <= '0;
      r_txn_block <= 1'b1;
    end else begin
      case (r_state)
        Q_STOPPED: begin
          r_txn_block <= 1'b1;
          if (w_sqreqn) r_state <= Q_EXIT;
        end
        Q_EXIT: begin
          r_txn_block <= 1'b1;
          if (r_iso_ack) begin
            r_qaccept_n <= 1'b1;
            r_txn_block <= w_s_ctr;
            r_state     <= Q_RUN;
          end
        end
        Q_RUN: begin
          r_txn_block <= w_s_ctr;
          r_idle_cnt  <= '0;
          r_tot_cnt   <= '0;
          if (!w_sqreqn) r_state <= Q_REQUEST;
        end
        Q_REQUEST: begin
          r_txn_block <= w_s_ctr;
          if (w_sqreqn) begin
            r_state <= Q_RUN;
          end else if (w_accept) begin
            r_qaccept_n <= 1'b0;
            r_txn_block <= 1'b1;
            r_state     <= Q_STOPPED;
          end else if (w_deny) begin
            r_qdeny <= 1'b1;
            r_state <= Q_DENIED;
          end else begin
            r_tot_cnt  <= r_tot_cnt + 1'b1;
            r_idle_cnt <= w_busy ? '0 : r_idle_cnt + 1'b1;
          end
        end
        Q_DENIED: begin
          r_txn_block <= w_s_ctr;
          if (w_sqreqn) begin
            r_qdeny <= 1'b0;
            r_state <= Q_CONTINUE;
          end
        end
        Q_CONTINUE: begin
          r_txn_block <= w_s_ctr;
          r_state     <= Q_RUN;
        end
        default: r_state <= Q_STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_ctr_ack <= 1'b0;
    else if (!w_s_ctr)                      r_ctr_ack <= 1'b0;
    else if ((r_cnt == '0) && r_txn_block)  r_ctr_ack <= 1'b1;
  end

  // Any change of target (including a reversal mid-countdown) restarts the delay from 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iso_ack  <= 1'b0;
      r_iso_pend <= 1'b0;
      r_iso_dir  <= 1'b0;
      r_iso_cnt  <= '0;
    end else if (w_iso_tgt == r_iso_ack) begin
      r_iso_pend <= 1'b0;
    end else if (!r_iso_pend || (r_iso_dir != w_iso_tgt)) begin
      r_iso_dir <= w_iso_tgt;
      r_iso_cnt <= ISO_W'(1);
      if (ISO_DLY == 1) begin
        r_iso_ack  <= w_iso_tgt;
        r_iso_pend <= 1'b0;
      end else begin
        r_iso_pend <= 1'b1;
      end
    end else if (r_iso_cnt == ISO_W'(ISO_DLY - 1)) begin
      r_iso_ack  <= w_iso_tgt;
      r_iso_pend <= 1'b0;
    end else begin
      r_iso_cnt <= r_iso_cnt + 1'b1;
    end
  end

  assign iso_ack_b            = r_iso_ack;
  assign QACCEPTn             = r_qaccept_n;
  assign QDENY                = r_qdeny;
  assign QACTIVE              = r_qactive;
  assign coherent_traffic_ack = r_ctr_ack;
  assign txn_block            = r_txn_block;
  assign outstanding          = r_cnt;
  assign pm_err               = r_err;

endmodule

// File: tb/tb_cdie_dielet_pm_responder.sv
// Directed handshake sequence plus a randomized counter phase checked against an integer model.
`timescale 1ns/1ps
module tb_cdie_dielet_pm_responder;

  localparam int SYNC  = 2;
  localparam int ACC   = 4;
  localparam int DENY  = 64;
  localparam int ISO   = 3;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic txn_start, txn_done, wake_req, iso_req_b, QREQn, coherent_traffic_req;
  logic iso_ack_b, QACCEPTn, QDENY, QACTIVE, coherent_traffic_ack, txn_block, pm_err;
  logic [CNT_W-1:0] outstanding;

  int n_total = 0;
  int n_pass  = 0;
  int m_cnt;
  bit st, dn, wk, exp_act;

  always #5 clk = ~clk;

  cdie_dielet_pm_responder dut (
    .clk(clk), .rst(rst),
    .txn_start(txn_start), .txn_done(txn_done), .wake_req(wake_req),
    .iso_req_b(iso_req_b), .iso_ack_b(iso_ack_b),
    .QREQn(QREQn), .QACCEPTn(QACCEPTn), .QDENY(QDENY), .QACTIVE(QACTIVE),
    .coherent_traffic_req(coherent_traffic_req), .coherent_traffic_ack(coherent_traffic_ack),
    .txn_block(txn_block), .outstanding(outstanding), .pm_err(pm_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("[%0t] %s observed=%0d expected=%0d ok", $time, tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_qacceptn"}, QACCEPTn, 0);
    chk({pfx, "_qdeny"}, QDENY, 0);
    chk({pfx, "_qactive"}, QACTIVE, 0);
    chk({pfx, "_iso_ack"}, iso_ack_b, 0);
    chk({pfx, "_ctr_ack"}, coherent_traffic_ack, 0);
    chk({pfx, "_txn_block"}, txn_block, 1);
    chk({pfx, "_outstanding"}, outstanding, 0);
    chk({pfx, "_pm_err"}, pm_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    txn_start = 0; txn_done = 0; wake_req = 0;
    iso_req_b = 0; QREQn = 0; coherent_traffic_req = 0;
    repeat (2) tick();
    chk_reset_values("reset");
    rst = 1'b0;
    tick();

    // Wake: isolation released and Q-channel exits to RUN
    QREQn = 1; iso_req_b = 1;
    repeat (SYNC + ISO - 1) tick();
    chk("wake_iso_early", iso_ack_b, 0);
    tick();
    chk("wake_iso_ack", iso_ack_b, 1);
    chk("wake_qaccept_early", QACCEPTn, 0);
    tick();
    chk("wake_qacceptn", QACCEPTn, 1);
    chk("wake_txn_block", txn_block, 0);

    // Randomized traffic in RUN against an integer count model
    m_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
      wk = ($urandom_range(0, 3) == 0);
      if (m_cnt == CMAX) st = 0;
      if (m_cnt == 0) dn = 0;
      txn_start = st; txn_done = dn; wake_req = wk;
      exp_act = (m_cnt != 0) || st || wk;
      if (st && !dn) m_cnt++;
      else if (dn && !st) m_cnt--;
      tick();
      chk("rand_outstanding", outstanding, m_cnt);
      chk("rand_qactive", QACTIVE, exp_act);
      chk("rand_pm_err", pm_err, 0);
    end
    txn_start = 0; txn_done = 0; wake_req = 0;
    while (m_cnt > 0) begin
      txn_done = 1;
      tick();
      m_cnt--;
    end
    txn_done = 0;
    chk("rand_drained", outstanding, 0);

    // Isolation request while running is held pending
    iso_req_b = 0;
    repeat (8) tick();
    chk("isogate_ack_held", iso_ack_b, 1);
    chk("isogate_no_err", pm_err, 0);

    // Accept with zero outstanding
    QREQn = 0;
    repeat (SYNC + ACC) tick();
    chk("accept_early", QACCEPTn, 1);
    tick();
    chk("accept_qacceptn", QACCEPTn, 0);
    chk("accept_qdeny", QDENY, 0);
    chk("accept_txn_block", txn_block, 1);
    repeat (ISO - 1) tick();
    chk("isogate_early", iso_ack_b, 1);
    tick();
    chk("isogate_isolated", iso_ack_b, 0);

    // Wake again
    QREQn = 1; iso_req_b = 1;
    repeat (SYNC + ISO + 1) tick();
    chk("rewake_qacceptn", QACCEPTn, 1);
    chk("rewake_iso_ack", iso_ack_b, 1);

    // Deny with three transactions outstanding
    txn_start = 1;
    repeat (3) tick();
    txn_start = 0;
    chk("deny_outstanding", outstanding, 3);
    chk("deny_no_err", pm_err, 0);
    QREQn = 0;
    repeat (SYNC + DENY) tick();
    chk("deny_early", QDENY, 0);
    tick();
    chk("deny_qdeny", QDENY, 1);
    chk("deny_qacceptn", QACCEPTn, 1);
    chk("deny_qactive", QACTIVE, 1);
    QREQn = 1;
    repeat (SYNC) tick();
    chk("deny_hold", QDENY, 1);
    tick();
    chk("deny_release", QDENY, 0);
    tick();
    chk("deny_pm_err", pm_err, 0);

    // Coherent drain
    txn_done = 1;
    tick();
    txn_done = 0;
    chk("drain_outstanding", outstanding, 2);
    coherent_traffic_req = 1;
    repeat (SYNC) tick();
    chk("drain_block_early", txn_block, 0);
    tick();
    chk("drain_block", txn_block, 1);
    chk("drain_ack_wait", coherent_traffic_ack, 0);
    repeat (3) tick();
    chk("drain_ack_held", coherent_traffic_ack, 0);
    txn_done = 1;
    repeat (2) tick();
    txn_done = 0;
    chk("drain_zero", outstanding, 0);
    chk("drain_ack_lag", coherent_traffic_ack, 0);
    tick();
    chk("drain_ack", coherent_traffic_ack, 1);
    tick();
    chk("drain_qactive", QACTIVE, 1);
    coherent_traffic_req = 0;
    repeat (SYNC) tick();
    chk("drain_ack_stay", coherent_traffic_ack, 1);
    tick();
    chk("drain_ack_drop", coherent_traffic_ack, 0);
    chk("drain_unblock", txn_block, 0);
    chk("drain_pm_err", pm_err, 0);

    // Counter error boundaries
    txn_done = 1;
    tick();
    txn_done = 0;
    chk("err_underflow_cnt", outstanding, 0);
    chk("err_underflow_flag", pm_err, 1);
    txn_start = 1;
    repeat (5) tick();
    txn_done = 1;
    tick();
    txn_start = 0; txn_done = 0;
    chk("err_both_same", outstanding, 5);
    txn_start = 1;
    repeat (CMAX - 5) tick();
    chk("err_at_max", outstanding, CMAX);
    tick();
    txn_start = 0;
    chk("err_overflow_held", outstanding, CMAX);

    // Asynchronous reset in the middle of Q_REQUEST
    QREQn = 0;
    repeat (SYNC + 3) tick();
    chk("midreq_qacceptn", QACCEPTn, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("midreq_rst");
    tick();
    rst = 1'b0;

    // Issue while blocked after reset
    txn_start = 1;
    tick();
    txn_start = 0;
    chk("blocked_start_cnt", outstanding, 1);
    chk("blocked_start_err", pm_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
